// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between the instruction fetch path (IFU, read-only)
// and the load/store path (LSU, read/write). One transaction is in flight at a
// time. Request, memory and response phases all use valid/ready handshakes,
// and a watchdog returns an error response if memory never answers.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width (write mask is DATA_W/8 bits)
//   TIMEOUT  cycles to wait for a memory response before erroring; 0 = off
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   ifu_req_* / ifu_addr          IFU read request handshake and address
//   ifu_resp_*                    IFU response handshake, data, watchdog error
//   lsu_req_* / lsu_addr/wen/...  LSU request handshake and write fields
//   lsu_resp_*                    LSU response handshake, data, watchdog error
//   mem_req_* / mem_addr/wen/...  request toward the memory
//   mem_resp_valid/data           memory response (reads and write acks)
//   grant                         owner of current transaction (0 IFU, 1 LSU)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_data,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                lsu_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,

  output logic                grant
);

  localparam int MASK_W = DATA_W / 8;
  // Keep the counter at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit   WDOG_ON  = (TIMEOUT > 0);

  // Master encoding shared by grant and the round-robin pointer.
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q,  state_d;
  logic                last_q,   last_d;
  logic                grant_q,  grant_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic                wen_q,    wen_d;
  logic [MASK_W-1:0]   wmask_q,  wmask_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;
  logic                err_q,    err_d;

  logic                is_idle;
  logic                pick_lsu;
  logic                resp_ready;

  // ---------------------------------------------------------------------------
  // Arbitration: combinational in IDLE. On a tie the master that was not
  // granted last wins; last_q resets to LSU so the IFU wins the first tie.
  // ---------------------------------------------------------------------------
  assign is_idle       = (state_q == S_IDLE);
  assign pick_lsu      = lsu_req_valid && (!ifu_req_valid || (last_q == OWNER_IFU));
  assign ifu_req_ready = is_idle && ifu_req_valid && !pick_lsu;
  assign lsu_req_ready = is_idle && pick_lsu;

  assign resp_ready    = (grant_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath latching
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is defaulted first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (lsu_req_ready) begin
          state_d = S_ISSUE;
          grant_d = OWNER_LSU;
          last_d  = OWNER_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wmask_d = lsu_wmask;
          wdata_d = lsu_wdata;
        end else if (ifu_req_ready) begin
          // The IFU is read-only: write enable and mask are forced off.
          state_d = S_ISSUE;
          grant_d = OWNER_IFU;
          last_d  = OWNER_IFU;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wmask_d = '0;
          wdata_d = '0;
        end
      end

      S_ISSUE: begin
        // A memory response here is ignored; memory may only answer in WAIT.
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_RESP;
          rdata_d = mem_resp_data;
          err_d   = 1'b0;
        end else if (WDOG_ON && (cnt_q == CNT_LAST)) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset abandons any transaction without a response.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q  <= OWNER_LSU;
      grant_q <= OWNER_IFU;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state or driven straight from registers.
  // ---------------------------------------------------------------------------
  assign mem_req_valid  = (state_q == S_ISSUE);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wmask      = wmask_q;
  assign mem_wdata      = wdata_q;

  assign ifu_resp_valid = (state_q == S_RESP) && (grant_q == OWNER_IFU);
  assign lsu_resp_valid = (state_q == S_RESP) && (grant_q == OWNER_LSU);
  assign ifu_resp_data  = rdata_q;
  assign lsu_resp_data  = rdata_q;
  assign ifu_resp_err   = err_q;
  assign lsu_resp_err   = err_q;

  assign grant          = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (TIMEOUT = 8). A per-cycle vector table
// covers the basic IFU read, tie arbitration and a stalled LSU write; short
// hand-written sequences cover response back-pressure, the watchdog with a
// late memory response, and reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  localparam logic [AW-1:0] IA = 32'h8000_0000;
  localparam logic [AW-1:0] LA = 32'h8000_0010;
  localparam logic [DW-1:0] WD = 32'hDEAD_BEEF;
  localparam logic [MW-1:0] WM = 4'h3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [DW-1:0] ifu_resp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [MW-1:0] lsu_wmask;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [DW-1:0] lsu_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata, mem_resp_data;
  logic          grant;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_resp_data  (ifu_resp_data),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wmask      (lsu_wmask),
    .lsu_wdata      (lsu_wdata),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_resp_data  (lsu_resp_data),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wmask      (mem_wmask),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .grant          (grant)
  );

  always #5 clk = ~clk;

  // Per-cycle stimulus and the outputs expected in that same cycle.
  typedef struct packed {
    logic          ifu_v;
    logic          lsu_v;
    logic          mreq_rdy;
    logic          mresp_v;
    logic [DW-1:0] mresp_data;
    logic          ifu_rrdy;
    logic          lsu_rrdy;
  } stim_t;

  typedef struct packed {
    logic          ifu_rdy;
    logic          lsu_rdy;
    logic          mreq_v;
    logic [AW-1:0] maddr;
    logic          mwen;
    logic [MW-1:0] mwmask;
    logic          ifu_rv;
    logic          lsu_rv;
    logic [DW-1:0] rdata;   // data of whichever response is valid, else 0
    logic          rerr;
    logic          grant;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic stim_t st(logic iv, logic lv, logic mr, logic mv,
                               logic [DW-1:0] md, logic irr, logic lrr);
    stim_t s;
    s.ifu_v = iv; s.lsu_v = lv; s.mreq_rdy = mr; s.mresp_v = mv;
    s.mresp_data = md; s.ifu_rrdy = irr; s.lsu_rrdy = lrr;
    return s;
  endfunction

  function automatic obs_t ob(logic ir, logic lr, logic mv, logic [AW-1:0] ma,
                              logic mw, logic [MW-1:0] mm, logic irv, logic lrv,
                              logic [DW-1:0] rd, logic re, logic g);
    obs_t o;
    o.ifu_rdy = ir; o.lsu_rdy = lr; o.mreq_v = mv; o.maddr = ma; o.mwen = mw;
    o.mwmask = mm; o.ifu_rv = irv; o.lsu_rv = lrv; o.rdata = rd; o.rerr = re;
    o.grant = g;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.ifu_rdy = ifu_req_ready;
    o.lsu_rdy = lsu_req_ready;
    o.mreq_v  = mem_req_valid;
    o.maddr   = mem_addr;
    o.mwen    = mem_wen;
    o.mwmask  = mem_wmask;
    o.ifu_rv  = ifu_resp_valid;
    o.lsu_rv  = lsu_resp_valid;
    o.rdata   = ifu_resp_valid ? ifu_resp_data : (lsu_resp_valid ? lsu_resp_data : '0);
    o.rerr    = ifu_resp_valid ? ifu_resp_err  : (lsu_resp_valid ? lsu_resp_err  : 1'b0);
    o.grant   = grant;
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    ifu_req_valid  = s.ifu_v;
    lsu_req_valid  = s.lsu_v;
    mem_req_ready  = s.mreq_rdy;
    mem_resp_valid = s.mresp_v;
    mem_resp_data  = s.mresp_data;
    ifu_resp_ready = s.ifu_rrdy;
    lsu_resp_ready = s.lsu_rrdy;
  endtask

  // One cycle: drive just after the rising edge, then sample on the falling edge.
  task automatic go(input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
    @(negedge clk);
  endtask

  task automatic add(input stim_t s, input obs_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    obs_t o;
    stim_t zero;
    zero = st(0, 0, 0, 0, '0, 0, 0);

    // -------------------------------------------------------------------------
    // Vector table: one entry per clock cycle, starting right after reset.
    // -------------------------------------------------------------------------
    // Tie after reset: IFU wins; LSU keeps requesting.
    add(st(1,1,0,0,'0,0,0),            ob(1,0,0,'0,0,'0,0,0,'0,0,0));
    add(st(0,1,1,0,'0,0,0),            ob(0,0,1,IA,0,'0,0,0,'0,0,0));
    add(st(0,1,0,1,32'h0000_0413,0,0), ob(0,0,0,IA,0,'0,0,0,'0,0,0));
    add(st(0,1,0,0,'0,1,0),            ob(0,0,0,IA,0,'0,1,0,32'h0000_0413,0,0));
    // Second tie: LSU wins; its write stalls with mem_req_ready low 5 cycles.
    add(st(1,1,0,0,'0,0,0),            ob(0,1,0,IA,0,'0,0,0,'0,0,0));
    for (int k = 0; k < 5; k++)
      add(st(1,0,0,0,'0,0,0),          ob(0,0,1,LA,1,WM,0,0,'0,0,1));
    add(st(1,0,1,0,'0,0,0),            ob(0,0,1,LA,1,WM,0,0,'0,0,1));
    add(st(1,0,0,1,32'h1234_5678,0,0), ob(0,0,0,LA,1,WM,0,0,'0,0,1));
    add(st(1,0,0,0,'0,0,0),            ob(0,0,0,LA,1,WM,0,1,32'h1234_5678,0,1));
    add(st(1,0,0,0,'0,0,1),            ob(0,0,0,LA,1,WM,0,1,32'h1234_5678,0,1));
    // Back in IDLE: the waiting IFU is accepted now.
    add(st(1,0,0,0,'0,0,0),            ob(1,0,0,LA,1,WM,0,0,'0,0,1));
    add(st(0,0,1,0,'0,0,0),            ob(0,0,1,IA,0,'0,0,0,'0,0,0));
    add(st(0,0,0,1,32'hCAFE_0001,0,0), ob(0,0,0,IA,0,'0,0,0,'0,0,0));
    add(st(0,0,0,0,'0,1,1),            ob(0,0,0,IA,0,'0,1,0,32'hCAFE_0001,0,0));

    ifu_addr  = IA;
    lsu_addr  = LA;
    lsu_wen   = 1'b1;
    lsu_wmask = WM;
    lsu_wdata = WD;
    drive(zero);

    // -------------------------------------------------------------------------
    // Reset state, and req_ready following arbitration while in reset.
    // -------------------------------------------------------------------------
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", observe(), ob(0,0,0,'0,0,'0,0,0,'0,0,0));
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    check("reset_tie_ready", observe(), ob(1,0,0,'0,0,'0,0,0,'0,0,0));
    drive(zero);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      go(vecs[i].s);
      check($sformatf("vec%0d", i), observe(), vecs[i].e);
      if (vecs[i].e.mwen && vecs[i].e.mreq_v)
        check($sformatf("vec%0d_wdata", i), mem_wdata, WD);
    end

    // -------------------------------------------------------------------------
    // IFU response held off 3 cycles; LSU must not be accepted meanwhile.
    // -------------------------------------------------------------------------
    lsu_wen = 1'b0;
    go(st(1,0,0,0,'0,0,0));
    check("hold_accept", observe(), ob(1,0,0,IA,0,'0,0,0,'0,0,0));
    go(st(0,1,1,0,'0,0,0));
    check("hold_issue", observe(), ob(0,0,1,IA,0,'0,0,0,'0,0,0));
    go(st(0,1,0,1,32'h55AA_55AA,0,0));
    for (int k = 0; k < 3; k++) begin
      go(st(0,1,0,0,'0,0,0));
      check($sformatf("hold_resp%0d", k), observe(), ob(0,0,0,IA,0,'0,1,0,32'h55AA_55AA,0,0));
    end
    go(st(0,1,0,0,'0,1,0));
    check("hold_release", observe(), ob(0,0,0,IA,0,'0,1,0,32'h55AA_55AA,0,0));

    // -------------------------------------------------------------------------
    // Watchdog: LSU read, memory silent -> err after 8 WAIT cycles; a late
    // response 10 cycles after entering WAIT has no effect.
    // -------------------------------------------------------------------------
    go(st(0,1,0,0,'0,0,0));
    check("wd_accept", observe(), ob(0,1,0,IA,0,'0,0,0,'0,0,0));
    go(st(0,0,1,0,'0,0,0));
    check("wd_issue", observe(), ob(0,0,1,LA,0,WM,0,0,'0,0,1));
    for (int k = 0; k < 8; k++) begin
      go(zero);
      check($sformatf("wd_wait%0d", k), observe(), ob(0,0,0,LA,0,WM,0,0,'0,0,1));
    end
    go(zero);
    check("wd_err", observe(), ob(0,0,0,LA,0,WM,0,1,'0,1,1));
    go(zero);
    check("wd_err_hold", observe(), ob(0,0,0,LA,0,WM,0,1,'0,1,1));
    go(st(0,0,0,1,32'hBAD0_BAD0,0,0));
    check("wd_late_cycle", observe(), ob(0,0,0,LA,0,WM,0,1,'0,1,1));
    go(st(0,0,0,0,'0,0,1));
    check("wd_late_ignored", observe(), ob(0,0,0,LA,0,WM,0,1,'0,1,1));
    go(st(0,0,0,1,32'h7777_7777,0,0));
    check("stray_idle", observe(), ob(0,0,0,LA,0,WM,0,0,'0,0,1));
    go(st(1,0,0,0,'0,0,0));
    check("post_wd_accept", observe(), ob(1,0,0,LA,0,WM,0,0,'0,0,1));
    go(st(0,0,1,0,'0,0,0));
    check("post_wd_issue", observe(), ob(0,0,1,IA,0,'0,0,0,'0,0,0));
    go(st(0,0,0,1,32'h0000_0413,0,0));
    go(st(0,0,0,0,'0,1,0));
    check("post_wd_resp", observe(), ob(0,0,0,IA,0,'0,1,0,32'h0000_0413,0,0));

    // -------------------------------------------------------------------------
    // Reset while in WAIT: valids drop at once; first tie afterwards is IFU,
    // the next tie is LSU.
    // -------------------------------------------------------------------------
    lsu_wen = 1'b1;
    go(st(0,1,0,0,'0,0,0));
    check("rw_accept", observe(), ob(0,1,0,IA,0,'0,0,0,'0,0,0));
    go(st(0,0,1,0,'0,0,0));
    go(zero);
    rst = 1'b0;
    #1;
    check("rw_async_reset", observe(), ob(0,0,0,'0,0,'0,0,0,'0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(st(1,1,0,0,'0,0,0));
    @(negedge clk);
    check("rw_tie1", observe(), ob(1,0,0,'0,0,'0,0,0,'0,0,0));
    go(st(0,1,1,0,'0,0,0));
    check("rw_tie1_issue", observe(), ob(0,0,1,IA,0,'0,0,0,'0,0,0));
    go(st(0,1,0,1,32'h1111_2222,0,0));
    go(st(0,1,0,0,'0,1,1));
    check("rw_tie1_resp", observe(), ob(0,0,0,IA,0,'0,1,0,32'h1111_2222,0,0));
    go(st(1,1,0,0,'0,0,0));
    check("rw_tie2", observe(), ob(0,1,0,IA,0,'0,0,0,'0,0,0));
    go(st(0,0,1,0,'0,0,0));
    check("rw_tie2_issue", observe(), ob(0,0,1,LA,1,WM,0,0,'0,0,1));
    check("rw_tie2_wdata", mem_wdata, WD);

    drive(zero);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, single-outstanding memory arbiter that shares one memory port between the instruction fetch path (IFU, read-only) and the load/store path (LSU, read/write). It sits between the IFU/LSU and the memory model, replacing direct combinational memory access so the core can run as a multi-cycle design. Request, memory and response phases all use valid/ready handshakes. A watchdog returns an error response if memory never answers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- TIMEOUT, 255, max cycles waiting for a memory response; 0 disables the watchdog

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU takes response
- ifu_resp_data  out  DATA_W  read data
- ifu_resp_err  out  1  response produced by watchdog
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W; lsu_wen  in  1 (1 = write); lsu_wmask  in  DATA_W/8; lsu_wdata  in  DATA_W
- lsu_resp_valid  out  1; lsu_resp_ready  in  1; lsu_resp_data  out  DATA_W; lsu_resp_err  out  1
- mem_req_valid  out  1; mem_req_ready  in  1
- mem_addr  out  ADDR_W; mem_wen  out  1; mem_wmask  out  DATA_W/8; mem_wdata  out  DATA_W
- mem_resp_valid  in  1  memory response (reads and writes); mem_resp_data  in  DATA_W
- grant  out  1  owner of current transaction (0 = IFU, 1 = LSU)

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Exactly one transaction in flight.
- IDLE: arbitration is combinational. Only one requester valid → it is granted. Both valid → round-robin: grant the master not granted last (pointer `last`, reset value LSU, so IFU wins the first tie). Granted master's req_ready = 1; the other's = 0. On accept, latch addr/wen/wmask/wdata (IFU forces wen = 0, wmask = 0), set grant, update `last`, go to ISSUE.
- ISSUE: mem_req_valid = 1 with latched fields. On mem_req_ready, go to WAIT, clear watchdog counter. mem_resp_valid during ISSUE is ignored; memory must not respond in the handshake cycle.
- WAIT: on mem_resp_valid, latch mem_resp_data, err = 0, go to RESP. Else, if TIMEOUT ≠ 0 and counter == TIMEOUT−1, latch data = 0, err = 1, go to RESP. Else increment counter (saturating, width clog2(TIMEOUT+1)).
- RESP: the granted master's resp_valid = 1 with latched data/err; other master's resp_valid = 0. On resp_ready, go to IDLE. No new request accepted in RESP.
- mem_resp_valid outside WAIT (late response after timeout, stray pulse) is dropped without effect.
- Requesters hold req fields stable while req_valid; the arbiter does not depend on that after accept.

## Timing
- Reset (rst low, async): state IDLE, `last` = LSU, grant = 0, counter = 0, latched data = 0, err = 0; all *_resp_valid, mem_req_valid = 0; mem_addr/wen/wmask/wdata = 0. Req_ready outputs follow the IDLE arbitration even during reset deassertion cycle. Reset mid-transaction abandons it; no response is produced.
- Best-case round trip, zero-wait memory and master: accept at edge T0; mem_req_valid high in cycle T0+1; WAIT in T0+2 with mem_resp_valid → resp_valid in T0+3; back in IDLE T0+4. Back-to-back accepts are 4 cycles apart.
- Outputs are registered or decoded from state only, except req_ready (combinational from req_valid, `last`, state).
- Watchdog: with TIMEOUT = N, the err response appears N cycles after entering WAIT if memory is silent.

## Test plan
- IFU only, addr 0x8000_0000, memory returns 0x0000_0413 one cycle after grant → ifu_resp_data = 0x0000_0413, err = 0, resp_valid in T0+3, mem_wen = 0.
- Both valid in the same cycle after reset, then both again → first grant IFU, second grant LSU; mem_addr matches each in turn; no response goes to the wrong master.
- LSU write addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 0x3 with mem_req_ready held low 5 cycles → mem_req_valid and fields stable 5 cycles; lsu_resp_valid after mem_resp_valid.
- TIMEOUT = 8, memory silent → lsu_resp_err = 1, data = 0, 8 cycles after entering WAIT; late mem_resp_valid in cycle 10 is ignored; next IFU read completes normally.
- ifu_resp_ready held low 3 cycles → ifu_resp_valid/data held; lsu request stays un-accepted until return to IDLE.
- rst low while in WAIT → all valids 0 immediately; after release, first tie grants IFU.
